fft_burst_arbiter: RTL and testbench

Shares one burst FFT/IFFT core between two independent streaming requesters, one whole frame at a time. Sits directly in front of the core's config, input-stream and output-stream interfaces. For each granted frame it:
- issues the owning requester's configuration word,
- passes that requester's input samples through to the core,
- steers the core's results back to the same requester.

Grants are round-robin between the two ports. Exactly one job is in flight at any time.

---
 rtl/fft_burst_arbiter.sv | 173 +++++++++++++++++
 tb/tb_fft_burst_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_burst_arbiter.sv
// Round-robin, frame-at-a-time sharing of one burst FFT/IFFT core between two streaming requesters.
// Define FFT_ARB_STATS_EN to add per-port completed-job counters (job_cnt0/job_cnt1).
module fft_burst_arbiter #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 9
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [4:0]                rq0_cfg,
   input  logic [4:0]                rq1_cfg,
   input  logic                      s0_valid,
   input  logic                      s0_last,
   input  logic [2*DATA_WIDTH-1:0]   s0_data,
   output logic                      s0_ready,
   input  logic                      s1_valid,
   input  logic                      s1_last,
   input  logic [2*DATA_WIDTH-1:0]   s1_data,
   output logic                      s1_ready,
   output logic                      m0_valid,
   output logic                      m0_last,
   output logic [2*DATA_WIDTH-1:0]   m0_data,
   output logic [ADDR_WIDTH:0]       m0_user,
   input  logic                      m0_ready,
   output logic                      m1_valid,
   output logic                      m1_last,
   output logic [2*DATA_WIDTH-1:0]   m1_data,
   output logic [ADDR_WIDTH:0]       m1_user,
   input  logic                      m1_ready,
   output logic                      core_cfg_valid,
   output logic [23:0]               core_cfg_data,
   input  logic                      core_cfg_ready,
   output logic                      core_s_valid,
   output logic                      core_s_last,
   output logic [2*DATA_WIDTH-1:0]   core_s_data,
   input  logic                      core_s_ready,
   input  logic                      core_m_valid,
   input  logic                      core_m_last,
   input  logic [2*DATA_WIDTH-1:0]   core_m_data,
   input  logic [ADDR_WIDTH:0]       core_m_user,
   output logic                      core_m_ready,
   output logic                      busy,
   output logic                      owner
`ifdef FFT_ARB_STATS_EN
   ,output logic [15:0]              job_cnt0
   ,output logic [15:0]              job_cnt1
`endif
);

   localparam int unsigned CFG_W      = 5;
   localparam int unsigned CORE_CFG_W = 24;

   typedef enum logic [1:0] {IDLE, CFG, LOAD, UNLOAD} state_t;

   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic [CFG_W-1:0] cfg_q, cfg_d;
   logic             grant_c;
   logic             load_done_c;
   logic             job_done_c;

   // Datapath steering: only the owner sees the core, and only in its phase.
   always_comb begin
      core_cfg_valid = (state_q == CFG);
      core_cfg_data  = {(CORE_CFG_W-CFG_W)'(0), cfg_q};
      busy           = (state_q != IDLE);
      owner          = owner_q;
      core_s_valid   = 1'b0;
      core_s_last    = 1'b0;
      core_s_data    = '0;
      core_m_ready   = 1'b0;
      s0_ready       = 1'b0;
      s1_ready       = 1'b0;
      m0_valid       = 1'b0;
      m0_last        = 1'b0;
      m0_data        = '0;
      m0_user        = '0;
      m1_valid       = 1'b0;
      m1_last        = 1'b0;
      m1_data        = '0;
      m1_user        = '0;
      if (state_q == LOAD) begin
         if (owner_q) begin
            core_s_valid = s1_valid;
            core_s_last  = s1_last;
            core_s_data  = s1_data;
            s1_ready     = core_s_ready;
         end else begin
            core_s_valid = s0_valid;
            core_s_last  = s0_last;
            core_s_data  = s0_data;
            s0_ready     = core_s_ready;
         end
      end
      if (state_q == UNLOAD) begin
         if (owner_q) begin
            m1_valid     = core_m_valid;
            m1_last      = core_m_last;
            m1_data      = core_m_data;
            m1_user      = core_m_user;
            core_m_ready = m1_ready;
         end else begin
            m0_valid     = core_m_valid;
            m0_last      = core_m_last;
            m0_data      = core_m_data;
            m0_user      = core_m_user;
            core_m_ready = m0_ready;
         end
      end
      load_done_c = (state_q == LOAD) & core_s_valid & core_s_ready & core_s_last;
      job_done_c  = (state_q == UNLOAD) & core_m_valid & core_m_ready & core_m_last;
   end

   // Job sequencing; on contention the port that did not go last wins.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cfg_d   = cfg_q;
      grant_c = (s0_valid & s1_valid) ? ~owner_q : s1_valid;
      case (state_q)
         IDLE: begin
            if (s0_valid | s1_valid) begin
               owner_d = grant_c;
               cfg_d   = grant_c ? rq1_cfg : rq0_cfg;
               state_d = CFG;
            end
         end
         CFG:     if (core_cfg_ready) state_d = LOAD;
         LOAD:    if (load_done_c)    state_d = UNLOAD;
         UNLOAD:  if (job_done_c)     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= 1'b1;
         cfg_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cfg_q   <= cfg_d;
      end
   end

`ifdef FFT_ARB_STATS_EN
   logic [15:0] job_cnt0_q, job_cnt0_d;
   logic [15:0] job_cnt1_q, job_cnt1_d;

   always_comb begin
      job_cnt0_d = job_cnt0_q;
      job_cnt1_d = job_cnt1_q;
      if (job_done_c) begin
         if (owner_q) job_cnt1_d = job_cnt1_q + 16'd1;
         else         job_cnt0_d = job_cnt0_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         job_cnt0_q <= '0;
         job_cnt1_q <= '0;
      end else begin
         job_cnt0_q <= job_cnt0_d;
         job_cnt1_q <= job_cnt1_d;
      end
   end

   assign job_cnt0 = job_cnt0_q;
   assign job_cnt1 = job_cnt1_q;
`endif

endmodule

// File: tb/tb_fft_burst_arbiter.sv
// Scoreboard bench for fft_burst_arbiter: the bench plays both requesters and the FFT core.
module tb_fft_burst_arbiter;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 9;

   logic          clk, rst;
   logic [4:0]    rq0_cfg, rq1_cfg;
   logic          s0_valid, s0_last, s0_ready, s1_valid, s1_last, s1_ready;
   logic [31:0]   s0_data, s1_data;
   logic          m0_valid, m0_last, m0_ready, m1_valid, m1_last, m1_ready;
   logic [31:0]   m0_data, m1_data;
   logic [9:0]    m0_user, m1_user;
   logic          core_cfg_valid, core_cfg_ready;
   logic [23:0]   core_cfg_data;
   logic          core_s_valid, core_s_last, core_s_ready;
   logic [31:0]   core_s_data;
   logic          core_m_valid, core_m_last, core_m_ready;
   logic [31:0]   core_m_data;
   logic [9:0]    core_m_user;
   logic          busy, owner;
`ifdef FFT_ARB_STATS_EN
   logic [15:0]   job_cnt0, job_cnt1;
`endif

   fft_burst_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .rq0_cfg(rq0_cfg), .rq1_cfg(rq1_cfg),
      .s0_valid(s0_valid), .s0_last(s0_last), .s0_data(s0_data), .s0_ready(s0_ready),
      .s1_valid(s1_valid), .s1_last(s1_last), .s1_data(s1_data), .s1_ready(s1_ready),
      .m0_valid(m0_valid), .m0_last(m0_last), .m0_data(m0_data), .m0_user(m0_user), .m0_ready(m0_ready),
      .m1_valid(m1_valid), .m1_last(m1_last), .m1_data(m1_data), .m1_user(m1_user), .m1_ready(m1_ready),
      .core_cfg_valid(core_cfg_valid), .core_cfg_data(core_cfg_data), .core_cfg_ready(core_cfg_ready),
      .core_s_valid(core_s_valid), .core_s_last(core_s_last), .core_s_data(core_s_data), .core_s_ready(core_s_ready),
      .core_m_valid(core_m_valid), .core_m_last(core_m_last), .core_m_data(core_m_data), .core_m_user(core_m_user),
      .core_m_ready(core_m_ready), .busy(busy), .owner(owner)
`ifdef FFT_ARB_STATS_EN
      , .job_cnt0(job_cnt0), .job_cnt1(job_cnt1)
`endif
   );

   typedef struct { logic port; logic [23:0] cfg; } job_t;

   int          checks = 0;
   int          failures = 0;
   job_t        exp_job[$];
   logic [32:0] exp_s0[$], exp_s1[$];
   logic [42:0] exp_m0[$], exp_m1[$];
   logic        job_port = 1'b0;
   logic        last_seen = 1'b0;
   int          cfg_stall = 0;
   logic        s_tog = 1'b0, m_tog = 1'b0;
   int          job_seq = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic miss(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=none expected=event t=%0t", name, $time);
   endtask

   // Requester side: drive one frame on port p, queueing each beat as it is offered.
   task automatic send_frame(input logic p, input int n, input logic [31:0] base, input logic with_last);
      int budget;
      for (int i = 0; i < n; i++) begin
         logic lst;
         lst = with_last && (i == n - 1);
         if (p) begin s1_valid = 1'b1; s1_data = base + 32'(i); s1_last = lst; exp_s1.push_back({lst, base + 32'(i)}); end
         else   begin s0_valid = 1'b1; s0_data = base + 32'(i); s0_last = lst; exp_s0.push_back({lst, base + 32'(i)}); end
         budget = 0;
         while (1) begin
            @(negedge clk);
            if (p ? s1_ready : s0_ready) break;
            budget++;
            if (budget > 1000) begin
               miss("s_ready_timeout");
               if (p) s1_valid = 1'b0; else s0_valid = 1'b0;
               return;
            end
         end
         @(posedge clk); #1;
      end
      if (p) begin s1_valid = 1'b0; s1_last = 1'b0; end
      else   begin s0_valid = 1'b0; s0_last = 1'b0; end
   endtask

   task automatic wait_done();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (!busy && !core_m_valid && exp_m0.size() == 0 && exp_m1.size() == 0 && exp_job.size() == 0) begin
            @(posedge clk); #1;
            return;
         end
      end
      miss("job_done_timeout");
   endtask

   task automatic run_job(input logic p, input logic [4:0] cfg, input logic [23:0] exp_cfg, input int n);
      if (p) rq1_cfg = cfg; else rq0_cfg = cfg;
      exp_job.push_back('{port: p, cfg: exp_cfg});
      send_frame(p, n, {8'hE0, 7'd0, p, 16'h0}, 1'b1);
      wait_done();
   endtask

   // Core model: accept config, absorb a frame, return one result per sample.
   task automatic core_job();
      int n;
      n = 0;
      while (1) begin
         @(negedge clk);
         if (core_cfg_valid && !rst) break;
         @(posedge clk); #1;
         core_cfg_ready = (cfg_stall == 0);
      end
      if (cfg_stall > 0) begin
         for (int i = 1; i < cfg_stall; i++) begin
            @(negedge clk);
            chk("cfg_hold", {core_cfg_valid, core_cfg_data}, {1'b1, 24'h000008});
         end
         @(posedge clk); #1 core_cfg_ready = 1'b1;
         @(posedge clk); #1 core_cfg_ready = (cfg_stall == 0);
      end else begin
         @(posedge clk); #1;
      end
      while (1) begin
         core_s_ready = s_tog ? ~core_s_ready : 1'b1;
         @(negedge clk);
         if (rst) begin core_s_ready = 1'b1; return; end
         if (core_s_valid && core_s_ready) begin
            n++;
            if (core_s_last) begin @(posedge clk); #1; break; end
         end
         @(posedge clk); #1;
      end
      core_s_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         logic [31:0] d;
         d = {16'(job_seq), 16'(k * 7 + 3)};
         core_m_valid = 1'b1;
         core_m_data  = d;
         core_m_user  = 10'(k);
         core_m_last  = (k == n - 1);
         if (job_port) exp_m1.push_back({core_m_last, 10'(k), d});
         else          exp_m0.push_back({core_m_last, 10'(k), d});
         while (1) begin
            @(negedge clk);
            if (rst) begin core_m_valid = 1'b0; core_m_last = 1'b0; return; end
            if (core_m_ready) break;
         end
         @(posedge clk); #1;
      end
      core_m_valid = 1'b0; core_m_last = 1'b0; core_m_data = '0; core_m_user = '0;
      job_seq++;
   endtask

   initial begin
      core_cfg_ready = 1'b1; core_s_ready = 1'b1;
      core_m_valid = 1'b0; core_m_last = 1'b0; core_m_data = '0; core_m_user = '0;
      forever core_job();
   end

   initial begin
      m0_ready = 1'b1; m1_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (m_tog) begin m0_ready = ~m0_ready; m1_ready = ~m1_ready; end
         else       begin m0_ready = 1'b1;      m1_ready = 1'b1;      end
      end
   end

   // Monitor: every handshake pops its expected beat.
   always @(negedge clk) begin : mon
      job_t        j;
      logic [32:0] es;
      logic [42:0] em;
      logic        leak;
      if (!rst) begin
         if (last_seen) chk("idle_gap", {busy, core_cfg_valid}, 64'd0);
         last_seen = 1'b0;
         if (core_cfg_valid && core_cfg_ready) begin
            if (exp_job.size() == 0) miss("unexpected_cfg");
            else begin
               j = exp_job.pop_front();
               chk("cfg_data", core_cfg_data, j.cfg);
               chk("owner", owner, j.port);
               job_port = j.port;
            end
         end
         if (core_s_valid && core_s_ready) begin
            if ((job_port ? exp_s1.size() : exp_s0.size()) == 0) miss("unexpected_core_s");
            else begin
               es = job_port ? exp_s1.pop_front() : exp_s0.pop_front();
               chk("core_s_beat", {core_s_last, core_s_data}, es);
            end
         end
         if (m0_valid && m0_ready) begin
            if (exp_m0.size() == 0) miss("unexpected_m0");
            else begin em = exp_m0.pop_front(); chk("m0_beat", {m0_last, m0_user, m0_data}, em); end
            if (m0_last) last_seen = 1'b1;
         end
         if (m1_valid && m1_ready) begin
            if (exp_m1.size() == 0) miss("unexpected_m1");
            else begin em = exp_m1.pop_front(); chk("m1_beat", {m1_last, m1_user, m1_data}, em); end
            if (m1_last) last_seen = 1'b1;
         end
         leak = (job_port ? (m0_valid | m0_last | s0_ready | (|m0_data) | (|m0_user))
                          : (m1_valid | m1_last | s1_ready | (|m1_data) | (|m1_user)))
              | (!busy & (s0_ready | s1_ready | m0_valid | m1_valid | core_s_valid | core_m_ready | core_cfg_valid));
         chk("port_isolation", leak, 64'd0);
      end
   end

   initial begin
      repeat (40000) @(posedge clk);
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; rq0_cfg = '0; rq1_cfg = '0;
      s0_valid = 1'b0; s0_last = 1'b0; s0_data = '0;
      s1_valid = 1'b0; s1_last = 1'b0; s1_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy_owner", {busy, owner}, 64'h1);
      chk("rst_cfg", {core_cfg_valid, core_cfg_data}, 64'd0);
      chk("rst_core_s", {core_s_valid, core_s_last, core_s_data, core_m_ready}, 64'd0);
      chk("rst_ports", {s0_ready, s1_ready, m0_valid, m0_last, m1_valid, m1_last}, 64'd0);
      chk("rst_mdata", {m0_data, m1_data}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;

      // Contention straight after reset: port 0 first, then port 1.
      rq0_cfg = 5'b01100; rq1_cfg = 5'b00111;
      exp_job.push_back('{port: 1'b0, cfg: 24'h00000C});
      exp_job.push_back('{port: 1'b1, cfg: 24'h000007});
      fork
         send_frame(1'b0, 8, 32'h0A00_0000, 1'b1);
         send_frame(1'b1, 8, 32'h0B00_0000, 1'b1);
      join
      wait_done();

      // Single 64-point FFT on port 0 with grant/config latency checks.
      rq0_cfg = 5'b01100;
      exp_job.push_back('{port: 1'b0, cfg: 24'h00000C});
      fork
         send_frame(1'b0, 64, 32'h1234_0000, 1'b1);
         begin
            @(negedge clk); chk("grant_t0", core_cfg_valid, 64'd0);
            @(negedge clk); chk("grant_t1", {core_cfg_valid, core_cfg_data}, {1'b1, 24'h00000C});
            @(negedge clk); chk("load_t2", {busy, core_s_valid, s0_ready}, 64'h7);
         end
      join
      wait_done();

      // Backpressure on config, input and result paths.
      cfg_stall = 5; s_tog = 1'b1; m_tog = 1'b1;
      @(posedge clk); #1;
      rq0_cfg = 5'b01000;
      exp_job.push_back('{port: 1'b0, cfg: 24'h000008});
      send_frame(1'b0, 16, 32'h5500_0000, 1'b1);
      wait_done();
      cfg_stall = 0; s_tog = 1'b0; m_tog = 1'b0;
      repeat (2) @(posedge clk); #1;

      // Config sampled once per grant.
      rq1_cfg = 5'b01001;
      exp_job.push_back('{port: 1'b1, cfg: 24'h000009});
      fork
         send_frame(1'b1, 16, 32'h6600_0000, 1'b1);
         begin
            for (int c = 0; c < 200 && !s1_ready; c++) @(negedge clk);
            @(posedge clk); #1 rq1_cfg = 5'b01000;
         end
      join
      wait_done();
      exp_job.push_back('{port: 1'b1, cfg: 24'h000008});
      send_frame(1'b1, 8, 32'h6700_0000, 1'b1);
      wait_done();

      // Reset in the middle of LOAD drops the frame.
      rq0_cfg = 5'b01100;
      exp_job.push_back('{port: 1'b0, cfg: 24'h00000C});
      send_frame(1'b0, 10, 32'h7700_0000, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy_owner", {busy, owner}, 64'h1);
      chk("midrst_handshakes", {core_cfg_valid, core_s_valid, core_m_ready, s0_ready, s1_ready, m0_valid, m1_valid}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      exp_job.push_back('{port: 1'b0, cfg: 24'h00000C});
      send_frame(1'b0, 16, 32'h7800_0000, 1'b1);
      wait_done();

      run_job(1'b0, 5'b00101, 24'h000005, 4);
      run_job(1'b1, 5'b00100, 24'h000004, 4);
      run_job(1'b0, 5'b00010, 24'h000002, 4);
      run_job(1'b1, 5'b00011, 24'h000003, 4);
`ifdef FFT_ARB_STATS_EN
      chk("job_cnt0", job_cnt0, 64'd3);
      chk("job_cnt1", job_cnt1, 64'd2);
      force dut.job_cnt0_q = 16'hFFFF;
      @(posedge clk); #1 release dut.job_cnt0_q;
      run_job(1'b0, 5'b00010, 24'h000002, 4);
      chk("job_cnt0_wrap", job_cnt0, 64'd0);
`endif
      chk("queues_drained", 64'(exp_s0.size() + exp_s1.size() + exp_m0.size() + exp_m1.size() + exp_job.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
